jtag_tap_sampled: RTL and testbench
===================================

# jtag_tap_sampled

Oversampled JTAG test-access-port target running entirely in the system clock domain. TCK, TMS, TDI and TRST are synchronised and edge-detected against `clk_i`. The block implements the IEEE 1149.1 TAP state machine, a 5-bit IR, and four data registers: IDCODE, BYPASS, CONFREG, MEMACC. MEMACC turns JTAG shifts into single-beat requests on a req/gnt/rvalid memory port, so a host JTAG driver can read and write L2 through it.

## Interface
- `IDCODE_VALUE`, 32'h2495_11C3, value captured by IDCODE DR; bit0 must be 1
- `CONF_WIDTH`, 9, width of CONFREG
- `clk_i`  in  1  system clock; sole clock of the block
- `rst_i`  in  1  reset; synchronous, active-high
- `jtag_tck_i`  in  1  asynchronous JTAG clock pin
- `jtag_trst_ni`  in  1  asynchronous JTAG reset pin, active-low; synchronised, then acts as a synchronous TAP reset
- `jtag_tms_i`  in  1  mode select pin
- `jtag_tdi_i`  in  1  serial data in
- `jtag_tdo_o`  out  1  serial data out, registered
- `conf_reg_o`  out  CONF_WIDTH  CONFREG contents
- `mem_req_o`  out  1  memory request
- `mem_we_o`  out  1  1 = write
- `mem_addr_o`  out  32  byte address
- `mem_wdata_o`  out  32  write data
- `mem_gnt_i`  in  1  request accepted
- `mem_rvalid_i`  in  1  response valid; one per granted request
- `mem_rdata_i`  in  32  read data, valid with rvalid

## Operation
- **Input synchronisation:** each of tck, tms, tdi and trst_n passes through a 2-flop synchroniser. `tck_rise` and `tck_fall` are one-cycle pulses derived from the synchronised tck and its previous value.
- **TAP FSM:** the 16 standard states. The FSM advances only on `tck_rise`, using synchronised TMS.
  - Reset state: Test-Logic-Reset.
  - Entered on `rst_i`, on synchronised trst_n == 0, or on five TMS=1 rises.
- **IR:** 5 bits.
  - Capture-IR loads 5'b00101.
  - Shift-IR shifts LSB first, TDI into the MSB.
  - Update-IR latches the active instruction.
  - Test-Logic-Reset forces the active instruction to IDCODE.
- **Instruction map:**
  - 5'b00001 IDCODE (32 bits)
  - 5'b00100 CONFREG (CONF_WIDTH bits)
  - 5'b01000 MEMACC (65 bits)
  - 5'b11111 and all other codes: BYPASS (1 bit; Capture loads 0)
- **DR rules:** Capture-DR loads the capture value and Shift-DR shifts LSB first. Update-DR acts only for CONFREG and MEMACC.
- **CONFREG:** Capture loads the current `conf_reg_o`. Update-DR copies the shift register to `conf_reg_o`.
- **MEMACC shifted-in layout:** [64:33] addr, [32:1] wdata, [0] we.
- **MEMACC Update-DR:**
  - If idle: latch addr, wdata and we, then assert `mem_req_o`.
  - If busy (request or response outstanding): ignore the update and set the sticky `overrun` flag.
- **MEMACC capture layout:** [64:34] zero, [33] overrun, [32:1] rdata_buf, [0] done.
  - `done` clears on launch and sets when the transaction completes.
  - Capture clears `overrun` after loading it.
- **Memory FSM states:** IDLE, REQ, WAIT_R.
  - IDLE -> REQ on accepted update.
  - REQ holds req, we, addr and wdata stable until `mem_gnt_i`.
  - REQ -> WAIT_R on grant.
  - WAIT_R -> IDLE on `mem_rvalid_i`. For reads, `rdata_buf` is loaded from `mem_rdata_i`; for writes, `rdata_buf` is unchanged.
- **TDO:** serial output is the shift register LSB; the IR LSB is used in IR-shift states.
  - `jtag_tdo_o` is updated on `tck_fall` only.
  - Outside Shift-IR/Shift-DR it holds 0.
- **TAP reset via trst_n:** resets the TAP FSM, IR and TDO. It does not reset CONFREG or the memory FSM.
- **`rst_i`:** resets everything.

## Timing
- **Reset values:**
  - `jtag_tdo_o`=0, `conf_reg_o`=0
  - `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0
  - done=1, overrun=0, rdata_buf=0
- **Edge-detect latency:** pin edge to `tck_rise`/`tck_fall` pulse is 3 `clk_i` cycles.
- **TCK requirement:** TCK high and low phases must each be ≥ 4 `clk_i` periods; behaviour is undefined below this.
- **State register:** updates in the cycle after `tck_rise`. Shift and capture actions occur in that same cycle.
- **Update-DR actions:** execute in the cycle the FSM is in Update-DR with `tck_rise` pending exit. Exactly one launch per Update-DR visit.
- **Memory request:** `mem_req_o` rises 1 cycle after Update-DR action and falls in the cycle after `mem_gnt_i`=1. A grant in the first req cycle gives a 1-cycle req.
- **rvalid:** accepted only in WAIT_R. `rvalid` seen in IDLE/REQ is ignored.
- **Simultaneous events:**
  - Completion (rvalid) and Update-DR in the same cycle: completion wins, update is treated as busy and sets overrun.
  - Capture and overrun set in the same cycle: the flag is captured as 1 and stays set.
- **`rst_i` mid-transaction:** drops req immediately next cycle and the FSM returns to IDLE.

## Test plan
- **IDCODE after reset:** `rst_i` pulse, then 5 TMS=1, go to Shift-DR, shift 32 bits -> TDO stream equals 32'h2495_11C3 LSB first; IR capture shift reads 5'b00101.
- **BYPASS:** IR=5'b11111, shift 8'hA5 through DR -> TDO reproduces 8'hA5 delayed one TCK, preceded by 0.
- **CONFREG:** IR=5'b00100, shift 9'h012, Update-DR -> `conf_reg_o`=9'h012; recapture shifts out 9'h012.
- **MEMACC write/read:** write to addr 0 with data 32'hABBAABBA, gnt after 2 cycles -> one req with we=1 and correct addr/wdata. Read of addr 0 with rvalid returning 32'hABBAABBA -> capture gives done=1, rdata 32'hABBAABBA, overrun=0.
- **Overrun:** hold gnt low, issue a second Update-DR -> no second req; next capture bit33=1, done=0; the capture after that shows bit33=0.
- **Reset mid-operation:** trst_n low during Shift-DR -> FSM returns to Test-Logic-Reset, IR=IDCODE, `conf_reg_o` unchanged. Assert `rst_i` while req is pending -> `mem_req_o`=0 the next cycle.

Source files
------------

// File: rtl/jtag_tap_sampled.sv
// jtag_tap_sampled: IEEE 1149.1 TAP target oversampled in the clk_i domain, with
//   IDCODE / BYPASS / CONFREG / MEMACC data registers; MEMACC issues single-beat
//   memory requests. Latency: pin edge to tck_rise/tck_fall pulse is 3 clk_i cycles.
// Ports: clk_i/rst_i (sync, active-high); jtag_tck_i/tms_i/tdi_i/trst_ni async pins;
//   jtag_tdo_o registered TDO; conf_reg_o CONFREG; mem_* req/gnt/rvalid port.
module jtag_tap_sampled #(
  parameter logic [31:0] IDCODE_VALUE = 32'h2495_11C3,
  parameter int          CONF_WIDTH   = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  jtag_tck_i,
  input  logic                  jtag_trst_ni,
  input  logic                  jtag_tms_i,
  input  logic                  jtag_tdi_i,
  output logic                  jtag_tdo_o,
  output logic [CONF_WIDTH-1:0] conf_reg_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i
);

  localparam logic [3:0] TLR = 4'd0,  RTI = 4'd1,  SELDR = 4'd2,  CAPDR = 4'd3,
                         SHDR = 4'd4, EX1DR = 4'd5, PSDR = 4'd6,  EX2DR = 4'd7,
                         UPDR = 4'd8, SELIR = 4'd9, CAPIR = 4'd10, SHIR = 4'd11,
                         EX1IR = 4'd12, PSIR = 4'd13, EX2IR = 4'd14, UPIR = 4'd15;

  localparam logic [4:0] IR_IDCODE = 5'b00001;
  localparam logic [4:0] IR_CONF   = 5'b00100;
  localparam logic [4:0] IR_MEMACC = 5'b01000;

  localparam logic [1:0] M_IDLE = 2'd0, M_REQ = 2'd1, M_WAIT_R = 2'd2;

  // Synchronisers; tms/tdi get one extra stage so they line up with the edge pulses.
  logic tck_s1_q, tck_s2_q, tck_s3_q, tck_rise_q, tck_fall_q;
  logic tms_s1_q, tms_s2_q, tms_q, tdi_s1_q, tdi_s2_q, tdi_q;
  logic trst_s1_q, trst_s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {tck_s1_q, tck_s2_q, tck_s3_q, tck_rise_q, tck_fall_q} <= '0;
      {tms_s1_q, tms_s2_q, tms_q, tdi_s1_q, tdi_s2_q, tdi_q} <= '0;
      {trst_s1_q, trst_s2_q} <= '0;
    end else begin
      tck_s1_q   <= jtag_tck_i;
      tck_s2_q   <= tck_s1_q;
      tck_s3_q   <= tck_s2_q;
      tck_rise_q <= tck_s2_q & ~tck_s3_q;
      tck_fall_q <= ~tck_s2_q & tck_s3_q;
      tms_s1_q   <= jtag_tms_i;
      tms_s2_q   <= tms_s1_q;
      tms_q      <= tms_s2_q;
      tdi_s1_q   <= jtag_tdi_i;
      tdi_s2_q   <= tdi_s1_q;
      tdi_q      <= tdi_s2_q;
      trst_s1_q  <= jtag_trst_ni;
      trst_s2_q  <= trst_s1_q;
    end
  end

  logic [3:0]  tap_q, tap_d;
  logic [4:0]  ir_q, ir_sr_q;
  logic [64:0] dr_sr_q, dr_cap, dr_shift;
  logic        tdo_q;
  logic [CONF_WIDTH-1:0] conf_q;
  logic [1:0]  mem_st_q;
  logic        we_q, done_q, overrun_q;
  logic [31:0] addr_q, wdata_q, rdata_buf_q;
  logic        upd_dr, upd_mem, cap_mem;

  always_comb begin
    tap_d = tap_q;
    case (tap_q)
      TLR:     tap_d = tms_q ? TLR   : RTI;
      RTI:     tap_d = tms_q ? SELDR : RTI;
      SELDR:   tap_d = tms_q ? SELIR : CAPDR;
      CAPDR:   tap_d = tms_q ? EX1DR : SHDR;
      SHDR:    tap_d = tms_q ? EX1DR : SHDR;
      EX1DR:   tap_d = tms_q ? UPDR  : PSDR;
      PSDR:    tap_d = tms_q ? EX2DR : PSDR;
      EX2DR:   tap_d = tms_q ? UPDR  : SHDR;
      UPDR:    tap_d = tms_q ? SELDR : RTI;
      SELIR:   tap_d = tms_q ? TLR   : CAPIR;
      CAPIR:   tap_d = tms_q ? EX1IR : SHIR;
      SHIR:    tap_d = tms_q ? EX1IR : SHIR;
      EX1IR:   tap_d = tms_q ? UPIR  : PSIR;
      PSIR:    tap_d = tms_q ? EX2IR : PSIR;
      EX2IR:   tap_d = tms_q ? UPIR  : SHIR;
      default: tap_d = tms_q ? SELDR : RTI; // UPIR
    endcase
  end

  // TAP FSM, IR and TDO; trst_n resets only this part of the block.
  always_ff @(posedge clk_i) begin
    if (rst_i || !trst_s2_q) begin
      tap_q   <= TLR;
      ir_q    <= IR_IDCODE;
      ir_sr_q <= '0;
      tdo_q   <= 1'b0;
    end else begin
      if (tck_rise_q) begin
        tap_q <= tap_d;
        case (tap_q)
          CAPIR:   ir_sr_q <= 5'b00101;
          SHIR:    ir_sr_q <= {tdi_q, ir_sr_q[4:1]};
          UPIR:    ir_q    <= ir_sr_q;
          default: ;
        endcase
      end
      if (tap_q == TLR) ir_q <= IR_IDCODE;
      if (tck_fall_q) begin
        if (tap_q == SHIR)      tdo_q <= ir_sr_q[0];
        else if (tap_q == SHDR) tdo_q <= dr_sr_q[0];
        else                    tdo_q <= 1'b0;
      end
    end
  end

  always_comb begin
    dr_cap   = '0;
    dr_shift = '0;
    case (ir_q)
      IR_IDCODE: begin
        dr_cap[31:0]   = IDCODE_VALUE;
        dr_shift[31:0] = {tdi_q, dr_sr_q[31:1]};
      end
      IR_CONF: begin
        dr_cap[CONF_WIDTH-1:0]   = conf_q;
        dr_shift[CONF_WIDTH-1:0] = {tdi_q, dr_sr_q[CONF_WIDTH-1:1]};
      end
      IR_MEMACC: begin
        dr_cap   = {31'b0, overrun_q, rdata_buf_q, done_q};
        dr_shift = {tdi_q, dr_sr_q[64:1]};
      end
      default: dr_shift[0] = tdi_q; // BYPASS: capture value stays 0
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dr_sr_q <= '0;
    end else if (tck_rise_q) begin
      if (tap_q == CAPDR)     dr_sr_q <= dr_cap;
      else if (tap_q == SHDR) dr_sr_q <= dr_shift;
    end
  end

  // Gated by trst so a TAP reset arriving on an Update-DR exit cannot fire an action.
  assign upd_dr  = tck_rise_q && trst_s2_q && (tap_q == UPDR);
  assign upd_mem = upd_dr && (ir_q == IR_MEMACC);
  assign cap_mem = tck_rise_q && trst_s2_q && (tap_q == CAPDR) && (ir_q == IR_MEMACC);

  always_ff @(posedge clk_i) begin
    if (rst_i)                            conf_q <= '0;
    else if (upd_dr && ir_q == IR_CONF)   conf_q <= dr_sr_q[CONF_WIDTH-1:0];
  end

  // Memory FSM. A completion moves out of WAIT_R in the same cycle, so an
  // update arriving then still sees the block busy and flags overrun.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_st_q    <= M_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b1;
      overrun_q   <= 1'b0;
      rdata_buf_q <= '0;
    end else begin
      case (mem_st_q)
        M_REQ:    if (mem_gnt_i) mem_st_q <= M_WAIT_R;
        M_WAIT_R: if (mem_rvalid_i) begin
          mem_st_q <= M_IDLE;
          done_q   <= 1'b1;
          if (!we_q) rdata_buf_q <= mem_rdata_i;
        end
        default: ;
      endcase
      if (upd_mem && mem_st_q == M_IDLE) begin
        addr_q   <= dr_sr_q[64:33];
        wdata_q  <= dr_sr_q[32:1];
        we_q     <= dr_sr_q[0];
        done_q   <= 1'b0;
        mem_st_q <= M_REQ;
      end
      // Setting the flag takes priority over the clear-on-capture.
      if (upd_mem && mem_st_q != M_IDLE) overrun_q <= 1'b1;
      else if (cap_mem)                  overrun_q <= 1'b0;
    end
  end

  assign jtag_tdo_o  = tdo_q;
  assign conf_reg_o  = conf_q;
  assign mem_req_o   = (mem_st_q == M_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_jtag_tap_sampled.sv
module tb_jtag_tap_sampled;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        tck = 1'b0, trst_n = 1'b1, tms = 1'b0, tdi = 1'b0;
  logic        tdo;
  logic [8:0]  conf;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  jtag_tap_sampled dut (
    .clk_i(clk), .rst_i(rst_i), .jtag_tck_i(tck), .jtag_trst_ni(trst_n),
    .jtag_tms_i(tms), .jtag_tdi_i(tdi), .jtag_tdo_o(tdo), .conf_reg_o(conf),
    .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr), .mem_wdata_o(wdata),
    .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: grant on the third cycle of req, rvalid two cycles later.
  logic        gnt_en = 1'b1;
  logic [31:0] mem_arr [4];
  int          req_rises = 0;
  logic        last_we;
  logic [31:0] last_addr, last_wdata;

  initial begin
    int wait_cnt, rv_cnt;
    logic req_prev;
    logic [31:0] rd_pending;
    for (int i = 0; i < 4; i++) mem_arr[i] = '0;
    wait_cnt = 0; rv_cnt = 0; req_prev = 1'b0; rd_pending = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      gnt = 1'b0; rvalid = 1'b0;
      if (req && !req_prev) req_rises++;
      req_prev = req;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin rvalid = 1'b1; rdata = rd_pending; end
      end
      if (req && gnt_en) begin
        if (wait_cnt == 2) begin
          gnt = 1'b1; wait_cnt = 0; rv_cnt = 2;
          last_we = we; last_addr = addr; last_wdata = wdata;
          if (we) mem_arr[addr[3:2]] = wdata;
          rd_pending = mem_arr[addr[3:2]];
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  // One TCK period; tdo is sampled just before the rising edge.
  task automatic tick(input logic tms_v, input logic tdi_v, output logic tdo_v);
    tms = tms_v; tdi = tdi_v;
    repeat (6) @(posedge clk);
    #1 tdo_v = tdo;
    tck = 1'b1;
    repeat (6) @(posedge clk);
    #1 tck = 1'b0;
  endtask

  task automatic tap_reset();
    logic t;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, t);
    tick(1'b0, 1'b0, t);
  endtask

  // From RTI, back to RTI.
  task automatic shift_ir(input logic [4:0] din, output logic [4:0] dout);
    logic t;
    tick(1, 0, t); tick(1, 0, t); tick(0, 0, t); tick(0, 0, t);
    for (int i = 0; i < 5; i++) begin tick(i == 4, din[i], t); dout[i] = t; end
    tick(1, 0, t); tick(0, 0, t);
  endtask

  // From RTI to Exit1-DR.
  task automatic dr_shift(input int n, input logic [64:0] din, output logic [64:0] dout);
    logic t;
    dout = '0;
    tick(1, 0, t); tick(0, 0, t); tick(0, 0, t);
    for (int i = 0; i < n; i++) begin tick(i == n - 1, din[i], t); dout[i] = t; end
  endtask

  // Exit1-DR -> Update-DR -> RTI; the update action fires on the last rise.
  task automatic dr_finish();
    logic t;
    tick(1, 0, t); tick(0, 0, t);
  endtask

  task automatic shift_dr(input int n, input logic [64:0] din, output logic [64:0] dout);
    dr_shift(n, din, dout);
    dr_finish();
  endtask

  initial begin
    logic [4:0]  ir_out;
    logic [64:0] dout;
    logic        t;
    int          base;

    repeat (4) @(posedge clk);
    #1 rst_i = 1'b0;
    check("rst_tdo", tdo, 0);
    check("rst_conf", conf, 0);
    check("rst_req", req, 0);
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);

    // IDCODE after reset, then IR capture pattern.
    tap_reset();
    shift_dr(32, 65'h0, dout);
    check("idcode", dout[31:0], 32'h2495_11C3);
    shift_ir(5'b01000, ir_out);
    check("ir_capture", ir_out, 5'b00101);

    // MEMACC reset capture: done=1, overrun=0, rdata=0 (launches a read of addr 0).
    shift_dr(65, 65'h0, dout);
    check("memacc_rst_cap", dout, 65'h1);
    repeat (30) @(posedge clk);

    // BYPASS: A5 comes back one TCK late, led by the captured 0.
    shift_ir(5'b11111, ir_out);
    shift_dr(9, {56'h0, 1'b0, 8'hA5}, dout);
    check("bypass", dout[8:0], {8'hA5, 1'b0});

    // CONFREG write and recapture.
    shift_ir(5'b00100, ir_out);
    shift_dr(9, 65'h012, dout);
    check("conf_first_cap", dout[8:0], 9'h000);
    check("conf_update", conf, 9'h012);
    shift_dr(9, 65'h012, dout);
    check("conf_recapture", dout[8:0], 9'h012);

    // trst_n mid Shift-DR: CONFREG bit1 is on TDO before the reset.
    tick(1, 0, t); tick(0, 0, t); tick(0, 0, t); tick(0, 0, t);
    repeat (6) @(posedge clk);
    #1 check("tdo_before_trst", tdo, 1);
    trst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("trst_tdo", tdo, 0);
    trst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("trst_conf_kept", conf, 9'h012);
    tick(0, 0, t);
    shift_dr(32, 65'h0, dout);
    check("trst_ir_idcode", dout[31:0], 32'h2495_11C3);

    // MEMACC write then read of address 0.
    shift_ir(5'b01000, ir_out);
    base = req_rises;
    shift_dr(65, {32'h0, 32'hABBAABBA, 1'b1}, dout);
    repeat (30) @(posedge clk);
    check("wr_req_count", req_rises - base, 1);
    check("wr_we", last_we, 1);
    check("wr_addr", last_addr, 32'h0);
    check("wr_wdata", last_wdata, 32'hABBAABBA);
    shift_dr(65, 65'h0, dout);
    check("wr_done_cap", dout, 65'h1);
    repeat (30) @(posedge clk);
    check("rd_we", last_we, 0);
    shift_dr(65, 65'h0, dout);
    check("rd_done", dout[0], 1);
    check("rd_data", dout[32:1], 32'hABBAABBA);
    check("rd_overrun", dout[33], 0);
    repeat (30) @(posedge clk);

    // Overrun: second update while the first request is stalled.
    gnt_en = 1'b0;
    base = req_rises;
    shift_dr(65, {32'h4, 32'h1234_5678, 1'b1}, dout);
    repeat (10) @(posedge clk);
    check("ovr_first_req", req_rises - base, 1);
    shift_dr(65, {32'h4, 32'h1234_5678, 1'b1}, dout);
    repeat (10) @(posedge clk);
    check("ovr_no_second_req", req_rises - base, 1);
    dr_shift(65, 65'h0, dout);
    check("ovr_flag_set", dout[33], 1);
    check("ovr_done_clear", dout[0], 0);
    gnt_en = 1'b1;
    repeat (30) @(posedge clk);
    dr_finish();
    repeat (30) @(posedge clk);
    shift_dr(65, 65'h0, dout);
    check("ovr_flag_cleared", dout[33], 0);
    check("ovr_done_after", dout[0], 1);
    repeat (30) @(posedge clk);

    // rst_i with a request pending.
    gnt_en = 1'b0;
    shift_dr(65, 65'h0, dout);
    repeat (10) @(posedge clk);
    #1 check("req_pending", req, 1);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1 check("rst_drops_req", req, 0);
    check("rst_clears_conf", conf, 0);
    rst_i = 1'b0;
    gnt_en = 1'b1;
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
